sysbus_arbiter: RTL and testbench

Two-master arbiter and address decoder for the 32-bit system bus. It shares the single system-bus path into the data memory and the GEMM configuration space between the RISC-V core (master 0) and a second bus master (master 1, e.g. a DMA/loader).
- Requests are granted round-robin with a bounded hold (burst) limit.
- Each access is steered by address region to the memory or to the GEMM register file.
- The 1-cycle-late read data is returned only to the master that issued the read.

---
 rtl/sysbus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: two-master round-robin arbiter with a burst hold limit and
// an address-region decoder for the shared system bus. Master 0 is the core,
// master 1 a secondary master such as a DMA/loader.
//
// Handshake: a master raises req and holds it, together with its
// rdwr/addr/wr_data/mask, until it sees gnt in the same cycle. gnt is
// combinational and means "this access is on the bus now". A granted read
// returns one cycle later as a single-cycle rvalid pulse on the issuing
// master only. rd_data is shared by both masters and is meaningful only
// while that master's rvalid is high. There is no backpressure on the
// response path.
module sysbus_arbiter #(
  parameter int         BURST_MAX   = 4,
  parameter logic [3:0] GEMM_REGION = 4'b1001
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_rdwr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  input  logic [3:0]  m0_mask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rd_data,

  input  logic        m1_req,
  input  logic        m1_rdwr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  input  logic [3:0]  m1_mask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rd_data,

  output logic        mem_en,
  output logic        gemm_en,
  output logic        bus_rdwr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  output logic [3:0]  bus_mask,

  input  logic [31:0] mem_rd_data,
  input  logic [31:0] gemm_rd_data
);

  localparam int            HW       = $clog2(BURST_MAX + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(BURST_MAX);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  // Arbitration state.
  logic          owner;     // last granted master
  logic [HW-1:0] hold_cnt;  // consecutive grants to owner, 0 after an idle cycle
  logic          rr_ptr;    // master favoured when both start together

  // In-flight read tracking.
  logic          rpend;
  logic          rtag;
  logic          rsel_mem;
  logic          rsel_gemm;

  // Grant decision results.
  logic          gnt_any;
  logic          gnt_id;

  logic          own_req;
  logic          oth_req;
  logic          claim;
  logic          is_gemm;
  logic          is_read;
  logic [31:0]   addr_mux;

  assign own_req = owner ? m1_req : m0_req;
  assign oth_req = owner ? m0_req : m1_req;
  // The owner only has a claim if it was granted in the previous cycle;
  // after an idle cycle a simultaneous request is settled by rr_ptr.
  assign claim   = (hold_cnt != '0);

  // Grant selection: owner keeps the bus until its burst budget runs out
  // while the other master waits, then the other master takes over.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (rst) begin
      gnt_any = 1'b0;
    end else if (claim && own_req && ((hold_cnt < HOLD_MAX) || !oth_req)) begin
      gnt_any = 1'b1;
      gnt_id  = owner;
    end else if (claim && oth_req) begin
      gnt_any = 1'b1;
      gnt_id  = ~owner;
    end else if (m0_req ^ m1_req) begin
      gnt_any = 1'b1;
      gnt_id  = m1_req;
    end else if (m0_req && m1_req) begin
      gnt_any = 1'b1;
      gnt_id  = rr_ptr;
    end
  end

  assign m0_gnt = gnt_any & ~gnt_id;
  assign m1_gnt = gnt_any &  gnt_id;

  // Bus muxes: idle cycles fall back to master 0 with both enables low.
  always_comb begin
    addr_mux    = m0_addr;
    bus_rdwr    = m0_rdwr;
    bus_wr_data = m0_wr_data;
    bus_mask    = m0_mask;
    if (m1_gnt) begin
      addr_mux    = m1_addr;
      bus_rdwr    = m1_rdwr;
      bus_wr_data = m1_wr_data;
      bus_mask    = m1_mask;
    end
  end

  // Word-aligned downstream: the two low address bits are cleared.
  assign bus_addr = addr_mux & 32'hFFFF_FFFC;

  assign is_gemm = (bus_addr[31:28] == GEMM_REGION);
  assign gemm_en = gnt_any &  is_gemm;
  assign mem_en  = gnt_any & ~is_gemm;
  assign is_read = gnt_any & ~bus_rdwr;

  // Owner, burst counter and tie pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= 1'b0;
      hold_cnt <= '0;
      rr_ptr   <= 1'b0;
    end else if (gnt_any) begin
      if (gnt_id == owner) begin
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HOLD_ONE;
        end
      end else begin
        owner    <= gnt_id;
        hold_cnt <= HOLD_ONE;
      end
      rr_ptr <= ~gnt_id;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Read-return tracking: remember who read and from which region.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpend     <= 1'b0;
      rtag      <= 1'b0;
      rsel_mem  <= 1'b0;
      rsel_gemm <= 1'b0;
    end else begin
      rpend <= is_read;
      if (is_read) begin
        rtag      <= gnt_id;
        rsel_mem  <= ~is_gemm;
        rsel_gemm <=  is_gemm;
      end
    end
  end

  // A reset arriving while a read is in flight suppresses its response.
  assign m0_rvalid = rpend & ~rtag & ~rst;
  assign m1_rvalid = rpend &  rtag & ~rst;

  logic [31:0] rd_data;
  always_comb begin
    rd_data = mem_rd_data;
    if (rsel_gemm) begin
      rd_data = gemm_rd_data;
    end else if (rsel_mem) begin
      rd_data = mem_rd_data;
    end
  end

  assign m0_rd_data = rd_data;
  assign m1_rd_data = rd_data;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: grant/decode checks in the stimulus
// thread, read responses checked by a scoreboard monitor.
module tb_sysbus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_rdwr, m1_req, m1_rdwr;
  logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;
  logic [3:0]  m0_mask, m1_mask;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        mem_en, gemm_en, bus_rdwr;
  logic [31:0] bus_addr, bus_wr_data;
  logic [3:0]  bus_mask;
  logic [31:0] mem_rd_data, gemm_rd_data;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];  // {tag, data}

  sysbus_arbiter #(.BURST_MAX(4), .GEMM_REGION(4'b1001)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rdwr(m0_rdwr), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_mask(m0_mask), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_rdwr(m1_rdwr), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_mask(m1_mask), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rd_data(m1_rd_data),
    .mem_en(mem_en), .gemm_en(gemm_en), .bus_rdwr(bus_rdwr),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_mask(bus_mask),
    .mem_rd_data(mem_rd_data), .gemm_rd_data(gemm_rd_data)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic rdwr, input logic [31:0] addr,
                          input logic [31:0] data);
    m0_req = req; m0_rdwr = rdwr; m0_addr = addr; m0_wr_data = data; m0_mask = 4'hF;
  endtask

  task automatic drive_m1(input logic req, input logic rdwr, input logic [31:0] addr,
                          input logic [31:0] data);
    m1_req = req; m1_rdwr = rdwr; m1_addr = addr; m1_wr_data = data; m1_mask = 4'h3;
  endtask

  task automatic idle();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_gnt(input string name, input logic e0, input logic e1);
    @(negedge clk);
    check({name, "_gnt"}, {31'b0, m1_gnt, m0_gnt}, {31'b0, e1, e0});
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expected response.
  logic [32:0] got;
  always @(negedge clk) begin
    if (m0_rvalid && m1_rvalid) begin
      check("rvalid_both", 33'd1, 33'd0);
    end else if (m0_rvalid || m1_rvalid) begin
      got = m1_rvalid ? {1'b1, m1_rd_data} : {1'b0, m0_rd_data};
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", got, 33'h0_0000_0000 | {1'b0, 32'hFFFF_FFFF} ^ got ^ {1'b0, 32'hFFFF_FFFF} ^ 33'h1_0000_0000);
      end else begin
        check("rsp", got, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    mem_rd_data  = 32'h0;
    gemm_rd_data = 32'h0;
    step();
    // Request during reset must not be granted.
    drive_m0(1'b1, 1'b0, 32'h0000_0104, 32'h0);
    @(negedge clk);
    check("rst_gnt", {31'b0, m1_gnt, m0_gnt}, 33'd0);
    check("rst_en", {31'b0, gemm_en, mem_en}, 33'd0);
    check("rst_rvalid", {31'b0, m1_rvalid, m0_rvalid}, 33'd0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("idle_gnt", {31'b0, m1_gnt, m0_gnt}, 33'd0);
    check("idle_en", {31'b0, gemm_en, mem_en}, 33'd0);
    step();

    // m0 read of 0x104 (low address bits set to exercise masking).
    drive_m0(1'b1, 1'b0, 32'h0000_0107, 32'h0);
    @(negedge clk);
    check("rd0_gnt", {31'b0, m1_gnt, m0_gnt}, 33'd1);
    check("rd0_en", {31'b0, gemm_en, mem_en}, 33'd1);
    check("rd0_addr", {1'b0, bus_addr}, {1'b0, 32'h0000_0104});
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    step();
    idle();
    mem_rd_data  = 32'hDEAD_BEEF;
    gemm_rd_data = 32'h5555_5555;
    @(negedge clk);
    check("rd0_m1_rvalid", {32'b0, m1_rvalid}, 33'd0);
    step();

    // m1 write into GEMM space: no response must follow.
    drive_m1(1'b1, 1'b1, 32'h9000_0008, 32'h0000_0010);
    @(negedge clk);
    check("wr1_gnt", {31'b0, m1_gnt, m0_gnt}, 33'd2);
    check("wr1_en", {31'b0, gemm_en, mem_en}, 33'd2);
    check("wr1_rdwr", {32'b0, bus_rdwr}, 33'd1);
    check("wr1_data", {1'b0, bus_wr_data}, {1'b0, 32'h0000_0010});
    check("wr1_mask", {29'b0, bus_mask}, 33'h3);
    check("wr1_addr", {1'b0, bus_addr}, {1'b0, 32'h9000_0008});
    step();
    idle();
    step();

    // Fairness from reset: both request writes for 12 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_m0(1'b1, 1'b1, 32'h0000_0100, 32'h1);
      drive_m1(1'b1, 1'b1, 32'h0000_0200, 32'h2);
      check_gnt($sformatf("fair%0d", i), (i < 4 || i >= 8), (i >= 4 && i < 8));
      step();
    end
    idle();
    step();

    // Alternating reads, GEMM then memory.
    drive_m0(1'b1, 1'b0, 32'h9000_0000, 32'h0);
    @(negedge clk);
    check("alt0_en", {31'b0, gemm_en, mem_en}, 33'd2);
    check("alt0_gnt", {31'b0, m1_gnt, m0_gnt}, 33'd1);
    exp_q.push_back({1'b0, 32'h0000_0011});
    step();
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    gemm_rd_data = 32'h0000_0011;
    mem_rd_data  = 32'h0000_0099;
    @(negedge clk);
    check("alt1_en", {31'b0, gemm_en, mem_en}, 33'd1);
    check("alt1_gnt", {31'b0, m1_gnt, m0_gnt}, 33'd2);
    check("alt1_m0_rvalid", {32'b0, m0_rvalid}, 33'd1);
    exp_q.push_back({1'b1, 32'h0000_0022});
    step();
    idle();
    gemm_rd_data = 32'h0000_0077;
    mem_rd_data  = 32'h0000_0022;
    @(negedge clk);
    check("alt2_m1_rvalid", {32'b0, m1_rvalid}, 33'd1);
    step();

    // Reset while a read is in flight: the response is dropped.
    drive_m0(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    check_gnt("rstrd", 1'b1, 1'b0);
    step();
    idle();
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_t1", {31'b0, m1_rvalid, m0_rvalid}, 33'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rstrd_t2", {31'b0, m1_rvalid, m0_rvalid}, 33'd0);
    step();
    // Owner/hold/rr back at reset values: m0 wins the tie for a full burst.
    for (int i = 0; i < 5; i++) begin
      drive_m0(1'b1, 1'b1, 32'h0000_0400, 32'h4);
      drive_m1(1'b1, 1'b1, 32'h0000_0500, 32'h5);
      check_gnt($sformatf("postrst%0d", i), i < 4, i == 4);
      step();
    end
    idle();
    step();

    // Lone m1 back-to-back reads, then m0 preempts a saturated burst.
    for (int i = 0; i < 10; i++) begin
      drive_m1(1'b1, 1'b0, 32'h0000_0040 + 32'(4 * i), 32'h0);
      mem_rd_data = 32'h0000_1000 + 32'(i - 1);
      check_gnt($sformatf("lone%0d", i), 1'b0, 1'b1);
      exp_q.push_back({1'b1, 32'h0000_1000 + 32'(i)});
      step();
    end
    drive_m0(1'b1, 1'b1, 32'h0000_0600, 32'h6);
    mem_rd_data = 32'h0000_1009;
    check_gnt("preempt", 1'b1, 1'b0);
    step();
    idle();
    mem_rd_data = 32'h0000_ABCD;
    step();
    step();

    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
